// File: rtl/fp_pkg.sv
// fp_pkg: shared state/class encodings, flag indices, binary32 defaults and helpers
//   state_t  : FSM states IDLE/MUL/NORM/DONE
//   cls_t    : operand classes zero/denorm/inf/NaN/normal
//   F_*      : bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
//   classify : class of an operand from its exponent/fraction summary bits
//   qnan     : canonical quiet NaN pattern for any EW/MW, right-aligned in 64 bits
package fp_pkg;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;
    typedef enum logic [2:0] {C_ZERO, C_DENORM, C_INF, C_NAN, C_NORM} cls_t;
    localparam int F_INV = 3;
    localparam int F_OVF = 2;
    localparam int F_UNF = 1;
    localparam int F_NX = 0;
    localparam int EW_DEF = 8;
    localparam int MW_DEF = 23;
    localparam int SW = MW_DEF + 1;
    localparam int BIAS = 2 ** (EW_DEF - 1) - 1;
    localparam int EXP_MAX = 2 ** EW_DEF - 1;
    function automatic cls_t classify(input logic exp_ones, input logic exp_zero, input logic frac_zero);
        return exp_ones ? (frac_zero ? C_INF : C_NAN) : exp_zero ? (frac_zero ? C_ZERO : C_DENORM) : C_NORM;
    endfunction
    function automatic logic [63:0] qnan(input int ew, input int mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction
endpackage

// File: rtl/fp_mul_iter_if.sv
// fp_mul_iter_if: operand/result handshake bundle of the iterative FP multiplier
//   in_valid/in_ready/a/b       : operand side (master drives in_valid, a, b)
//   out_valid/out_ready/result/flags : result side (master drives out_ready)
//   master : operand-fetch / writeback view; slave : multiplier view
interface fp_mul_iter_if #(parameter int EW = 8, parameter int MW = 23);
    logic in_valid;
    logic in_ready;
    logic [EW+MW:0] a;
    logic [EW+MW:0] b;
    logic out_valid;
    logic out_ready;
    logic [EW+MW:0] result;
    logic [3:0] flags;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result, flags);
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_sig_mul_iter.sv
// fp_sig_mul_iter: iterative shift-add significand multiplier, BPC multiplier bits per cycle
//   clk, reset : clock and synchronous active-high reset
//   start      : load a/b and begin; ignored fields are reloaded on every start
//   a, b       : SW-bit unsigned significands
//   busy       : iteration in progress
//   done       : high during the last iteration cycle; product is final after that edge
//   product    : 2*SW-bit result
module fp_sig_mul_iter #(
    parameter int SW = 24,
    parameter int BPC = 1
) (
    input logic clk,
    input logic reset,
    input logic start,
    input logic [SW-1:0] a,
    input logic [SW-1:0] b,
    output logic busy,
    output logic done,
    output logic [2*SW-1:0] product
);
    localparam int N = SW / BPC;
    localparam int CW = $clog2(N + 1);
    if (SW % BPC != 0) begin : g_bad_bpc
        $error("BPC must divide SW");
    end
    logic [2*SW-1:0] mcand;
    logic [SW-1:0] mplier;
    logic [CW-1:0] cnt;
    logic [2*SW-1:0] partial;
    // Partial product for the BPC low multiplier bits retired this cycle
    always_comb begin
        partial = '0;
        for (int i = 0; i < BPC; i++)
            partial = partial + ({2*SW{mplier[i]}} & (mcand << i));
    end
    assign done = busy && cnt == CW'(N - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt <= '0;
            mcand <= '0;
            mplier <= '0;
            product <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt <= '0;
            mcand <= {{SW{1'b0}}, a};
            mplier <= b;
            product <= '0;
        end else if (busy) begin
            product <= product + partial;
            mcand <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt <= cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/fp_mul_iter.sv
// fp_mul_iter: IEEE-754 multiplier, RNE, DAZ/FTZ, canonical qNaN, iterative significand product
//   clk, reset : clock and synchronous active-high reset (aborts any op in flight)
//   bus.slave  : in_valid/in_ready/a/b operand handshake; out_valid/out_ready/result/flags result handshake
//   flags      : {invalid, overflow, underflow, inexact}, valid with out_valid
module fp_mul_iter
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23,
    parameter int BPC = 1
) (
    input logic clk,
    input logic reset,
    fp_mul_iter_if.slave bus
);
    localparam int W_SIG = MW + 1;
    localparam int PW = 2 * W_SIG;
    localparam int XW = EW + 2;
    localparam int E_BIAS = 2 ** (EW - 1) - 1;
    localparam int E_MAX = 2 ** EW - 1;
    localparam logic [63:0] QNAN64 = qnan(EW, MW);
    localparam logic [EW+MW:0] QNAN = QNAN64[EW+MW:0];
    state_t state, nstate;
    cls_t ca, cb, ca_r, cb_r;
    logic s_r;
    logic [EW-1:0] ea_r, eb_r;
    logic [EW+MW:0] res_r, res_n;
    logic [3:0] flg_r, flg_n;
    logic accept, mul_busy, mul_done;
    logic [PW-1:0] prod, ps;
    logic [XW-1:0] e0, e1, e2;
    logic [MW-1:0] frac, fr;
    logic hi, guard, sticky, rnd, carry, ovf, unf;
    logic nan_in, za, zb, ia, ib, zi, special;
    assign accept = state == S_IDLE && bus.in_valid;
    assign ca = classify(&bus.a[EW+MW-1:MW], ~|bus.a[EW+MW-1:MW], ~|bus.a[MW-1:0]);
    assign cb = classify(&bus.b[EW+MW-1:MW], ~|bus.b[EW+MW-1:MW], ~|bus.b[MW-1:0]);
    // Hidden bit only for normals; specials are resolved in NORM so their product is don't-care
    fp_sig_mul_iter #(.SW(W_SIG), .BPC(BPC)) u_sig (
        .clk(clk),
        .reset(reset),
        .start(accept),
        .a({ca == C_NORM, bus.a[MW-1:0]}),
        .b({cb == C_NORM, bus.b[MW-1:0]}),
        .busy(mul_busy),
        .done(mul_done),
        .product(prod)
    );
    always_comb begin
        nstate = state;
        nstate = state == S_IDLE ? (bus.in_valid ? S_MUL : S_IDLE)
               : state == S_MUL ? (mul_done || !mul_busy ? S_NORM : S_MUL)
               : state == S_NORM ? S_DONE
               : (bus.out_ready ? S_IDLE : S_DONE);
        bus.in_ready = state == S_IDLE;
        bus.out_valid = state == S_DONE;
        bus.result = res_r;
        bus.flags = flg_r;
    end
    // Normalise and round; exponent carried as EW+2 bits so its sign bit flags underflow
    always_comb begin
        hi = prod[PW-1];
        ps = hi ? prod : prod << 1;
        frac = ps[PW-2 -: MW];
        guard = ps[PW-2-MW];
        sticky = |ps[PW-3-MW:0];
        rnd = guard && (sticky || frac[0]);
        e0 = {2'b00, ea_r} + {2'b00, eb_r} - XW'(E_BIAS);
        e1 = e0 + {{(XW-1){1'b0}}, hi};
        {carry, fr} = {1'b0, frac} + {{MW{1'b0}}, rnd};
        e2 = e1 + {{(XW-1){1'b0}}, carry};
        ovf = !e2[XW-1] && e2 >= XW'(E_MAX);
        unf = e2[XW-1] || e2 == '0;
        nan_in = ca_r == C_NAN || cb_r == C_NAN;
        za = ca_r == C_ZERO || ca_r == C_DENORM;
        zb = cb_r == C_ZERO || cb_r == C_DENORM;
        ia = ca_r == C_INF;
        ib = cb_r == C_INF;
        zi = (za && ib) || (ia && zb);
        special = nan_in || ia || ib || za || zb;
        res_n = nan_in || zi ? QNAN
              : ia || ib || (!special && ovf) ? {s_r, {EW{1'b1}}, {MW{1'b0}}}
              : za || zb || unf ? {s_r, {(EW+MW){1'b0}}}
              : {s_r, e2[EW-1:0], fr};
        flg_n = '0;
        flg_n[F_INV] = zi && !nan_in;
        flg_n[F_OVF] = !special && ovf;
        flg_n[F_UNF] = !special && !ovf && unf;
        flg_n[F_NX] = !special && (ovf || unf || guard || sticky);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ca_r <= C_ZERO;
            cb_r <= C_ZERO;
            s_r <= 1'b0;
            ea_r <= '0;
            eb_r <= '0;
            res_r <= '0;
            flg_r <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                ca_r <= ca;
                cb_r <= cb;
                s_r <= bus.a[EW+MW] ^ bus.b[EW+MW];
                ea_r <= bus.a[EW+MW-1:MW];
                eb_r <= bus.b[EW+MW-1:MW];
            end
            if (state == S_NORM) begin
                res_r <= res_n;
                flg_r <= flg_n;
            end
        end
    end
endmodule
